// File: rtl/register_file.sv
// Two-read, one-write register file with registered reads,
// write-first bypass, optional zero register and range error pulse.
module register_file #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             err
);

    // One extra bit so DEPTH itself is representable for the range test.
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_err;

    logic             w_wa_ok;
    logic             w_ra_ok;
    logic             w_rb_ok;
    logic             w_wr_zero;
    logic             w_wr_en;
    logic             w_err;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;

    // Range checks on the zero-extended address: no wrap-around aliasing.
    assign w_wa_ok = ({1'b0, waddr}   < LP_DEPTH);
    assign w_ra_ok = ({1'b0, raddr_a} < LP_DEPTH);
    assign w_rb_ok = ({1'b0, raddr_b} < LP_DEPTH);

    // A write to the hardwired zero entry is legal but has no effect.
    assign w_wr_zero = ZERO_REG && (waddr == '0);
    assign w_wr_en   = we && w_wa_ok && !w_wr_zero;

    // Any enabled access outside the array raises the error pulse.
    assign w_err = (we   && !w_wa_ok)
                 || (re_a && !w_ra_ok)
                 || (re_b && !w_rb_ok);

    // Port A read data: zero out of range / zero reg, else write-first.
    always_comb begin
        w_rd_a = '0;
        if (w_ra_ok && !(ZERO_REG && raddr_a == '0)) begin
            if (w_wr_en && (raddr_a == waddr)) begin
                w_rd_a = wdata;
            end else begin
                w_rd_a = r_mem[raddr_a];
            end
        end
    end

    // Port B read data: same selection as port A, independent address.
    always_comb begin
        w_rd_b = '0;
        if (w_rb_ok && !(ZERO_REG && raddr_b == '0)) begin
            if (w_wr_en && (raddr_b == waddr)) begin
                w_rd_b = wdata;
            end else begin
                w_rd_b = r_mem[raddr_b];
            end
        end
    end

    // Storage array: cleared on reset, which also discards any write.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read ports hold their value while not enabled.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            if (re_a) begin
                r_rdata_a <= w_rd_a;
            end
            if (re_b) begin
                r_rdata_b <= w_rd_b;
            end
        end
    end

    // Error flag lasts exactly one cycle after the offending edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign err     = r_err;

endmodule
